// File: rtl/fib_concat_pack.sv
// rtl/fib_concat_pack.sv - packs NSEG Fibonacci codewords LSB-first into one data frame plus separator frame
module fib_concat_pack #(
    parameter int NSEG  = 3,
    parameter int W     = 32,
    parameter int OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     in_word,
    input  logic [5:0]       in_len,
    output logic [OUT_W-1:0] out_F,
    output logic [OUT_W-1:0] out_S,
    output logic             seg_done,
    output logic             done_pack,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_NEXT   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     word, word_nxt;
    logic [5:0]       eff_len, eff_len_nxt;
    logic [5:0]       bit_i, bit_i_nxt;
    logic [6:0]       pos, pos_nxt;
    logic [1:0]       seg_cnt, seg_cnt_nxt;
    logic [OUT_W-1:0] acc_F, acc_F_nxt;
    logic [OUT_W-1:0] acc_S, acc_S_nxt;
    logic [OUT_W-1:0] out_F_nxt, out_S_nxt;
    logic             seg_done_nxt, done_pack_nxt, err_nxt;

    // Length 0 and anything wider than a codeword both mean a full W-bit word.
    logic [5:0] len_clip;
    assign len_clip = (in_len == 6'd0 || in_len > 6'(W)) ? 6'(W) : in_len;

    logic             cur_bit;
    logic             last_bit;
    logic [OUT_W-1:0] one_hot;
    assign cur_bit  = word[bit_i[$clog2(W)-1:0]];
    assign last_bit = (bit_i == 6'(eff_len - 6'd1));
    assign one_hot  = {{(OUT_W-1){1'b0}}, 1'b1} << pos;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            word      <= '0;
            eff_len   <= '0;
            bit_i     <= '0;
            pos       <= '0;
            seg_cnt   <= '0;
            acc_F     <= '0;
            acc_S     <= '0;
            out_F     <= '0;
            out_S     <= '0;
            seg_done  <= 1'b0;
            done_pack <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            word      <= word_nxt;
            eff_len   <= eff_len_nxt;
            bit_i     <= bit_i_nxt;
            pos       <= pos_nxt;
            seg_cnt   <= seg_cnt_nxt;
            acc_F     <= acc_F_nxt;
            acc_S     <= acc_S_nxt;
            out_F     <= out_F_nxt;
            out_S     <= out_S_nxt;
            seg_done  <= seg_done_nxt;
            done_pack <= done_pack_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        word_nxt      = word;
        eff_len_nxt   = eff_len;
        bit_i_nxt     = bit_i;
        pos_nxt       = pos;
        seg_cnt_nxt   = seg_cnt;
        acc_F_nxt     = acc_F;
        acc_S_nxt     = acc_S;
        out_F_nxt     = out_F;
        out_S_nxt     = out_S;
        seg_done_nxt  = 1'b0;
        done_pack_nxt = 1'b0;
        err_nxt       = err;

        case (state)
            ST_IDLE: begin
                if (en) begin
                    word_nxt    = in_word;
                    eff_len_nxt = len_clip;
                    bit_i_nxt   = '0;
                    err_nxt     = 1'b0;
                    state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A full frame drops the codeword in flight; no separator or seg_done for it.
                if (pos == 7'(OUT_W)) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_FINISH;
                end else begin
                    if (cur_bit)  acc_F_nxt = acc_F | one_hot;
                    if (last_bit) acc_S_nxt = acc_S | one_hot;
                    pos_nxt   = pos + 7'd1;
                    bit_i_nxt = bit_i + 6'd1;
                    if (last_bit) state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                seg_done_nxt = 1'b1;
                if (seg_cnt == 2'(NSEG - 1)) begin
                    state_nxt = ST_FINISH;
                end else begin
                    seg_cnt_nxt = seg_cnt + 2'd1;
                    state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (en) begin
                    word_nxt    = in_word;
                    eff_len_nxt = len_clip;
                    bit_i_nxt   = '0;
                    state_nxt   = ST_SHIFT;
                end
            end
            ST_FINISH: begin
                out_F_nxt     = acc_F;
                out_S_nxt     = acc_S;
                done_pack_nxt = 1'b1;
                acc_F_nxt     = '0;
                acc_S_nxt     = '0;
                pos_nxt       = '0;
                seg_cnt_nxt   = '0;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fib_concat_pack.sv
// tb/tb_fib_concat_pack.sv - directed and round-trip checks for fib_concat_pack
module tb_fib_concat_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] in_word = '0;
    logic [5:0]  in_len = '0;
    logic [63:0] out_F, out_S;
    logic        seg_done, done_pack, err;

    fib_concat_pack #(.NSEG(3), .W(32), .OUT_W(64)) dut (
        .clk(clk), .rst(rst), .en(en), .in_word(in_word), .in_len(in_len),
        .out_F(out_F), .out_S(out_S), .seg_done(seg_done),
        .done_pack(done_pack), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int seg_pulses = 0;
    int dp_pulses = 0;
    bit dp_seen;

    always @(negedge clk) begin
        if (rst) begin
            if (seg_done)  seg_pulses++;
            if (done_pack) dp_pulses++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse en for one sample, then wait for seg_done, or done_pack when the word overflows.
    task automatic send(input logic [31:0] w, input logic [5:0] l);
        int t;
        bit got;
        in_word = w;
        in_len  = l;
        en      = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        dp_seen = 1'b0;
        got = 1'b0;
        t = 0;
        while (!got) begin
            @(negedge clk);
            if (seg_done) got = 1'b1;
            else if (done_pack) begin
                dp_seen = 1'b1;
                got = 1'b1;
            end else begin
                t++;
                if (t > 300) begin
                    check("send_timeout", 64'd0, 64'd1);
                    got = 1'b1;
                    dp_seen = 1'b1;
                end
            end
        end
    endtask

    task automatic frame(input logic [31:0] w0, input logic [5:0] l0,
                         input logic [31:0] w1, input logic [5:0] l1,
                         input logic [31:0] w2, input logic [5:0] l2);
        send(w0, l0);
        if (!dp_seen) send(w1, l1);
        if (!dp_seen) send(w2, l2);
        if (!dp_seen) begin
            @(negedge clk);
            check("done_pack_lat", {63'd0, done_pack}, 64'd1);
        end
        @(negedge clk);
        #1;
    endtask

    int s0, d0;
    logic [31:0] wv[3];
    logic [5:0]  lv[3];
    logic [31:0] got_w[3];
    logic [31:0] cur;
    int nseg, b;

    initial begin
        // T1: reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en = ~en;
            in_word = 32'hFFFF_0000 ^ in_word;
            in_len = 6'(i);
        end
        check("rst_F", out_F, 64'd0);
        check("rst_S", out_S, 64'd0);
        check("rst_flags", {61'd0, seg_done, done_pack, err}, 64'd0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_pulses", 64'(seg_pulses + dp_pulses), 64'd0);

        // T2: basic frame
        s0 = seg_pulses; d0 = dp_pulses;
        frame(32'h5, 6'd3, 32'h13, 6'd5, 32'hA, 6'd4);
        check("t2_F", out_F, 64'hA9D);
        check("t2_S", out_S, 64'h884);
        check("t2_err", {63'd0, err}, 64'd0);
        check("t2_seg", 64'(seg_pulses - s0), 64'd3);
        check("t2_dp", 64'(dp_pulses - d0), 64'd1);

        // T3: latency counted from the edge that samples en, then en held during SHIFT
        s0 = seg_pulses;
        @(negedge clk);
        in_word = 32'h1; in_len = 6'd1; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("lat_e1", {63'd0, seg_done}, 64'd0);
        @(negedge clk);
        check("lat_e2", {63'd0, seg_done}, 64'd0);
        @(negedge clk);
        check("lat_e3", {63'd0, seg_done}, 64'd1);
        in_word = 32'hA5; in_len = 6'd8; en = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("t3_seg_cnt", 64'(seg_pulses - s0), 64'd2);
        send(32'h3, 6'd2);
        @(negedge clk);
        check("t3_dp", {63'd0, done_pack}, 64'd1);
        check("t3_F", out_F, 64'h74B);
        check("t3_S", out_S, 64'h501);
        @(negedge clk);

        // T4: exactly-full frame followed by an overflowing codeword
        s0 = seg_pulses; d0 = dp_pulses;
        frame(32'hFFFF_FFFF, 6'd0, 32'h0, 6'd0, 32'h1, 6'd0);
        check("t4_F", out_F, 64'h0000_0000_FFFF_FFFF);
        check("t4_S", out_S, 64'h8000_0000_8000_0000);
        check("t4_err", {63'd0, err}, 64'd1);
        check("t4_seg", 64'(seg_pulses - s0), 64'd2);
        check("t4_dp", 64'(dp_pulses - d0), 64'd1);

        // T5: asynchronous reset in the middle of codeword 0
        @(negedge clk);
        in_word = 32'h5; in_len = 6'd3; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rst_F", out_F, 64'd0);
        check("t5_rst_S", out_S, 64'd0);
        check("t5_rst_flags", {61'd0, seg_done, done_pack, err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        s0 = seg_pulses;
        frame(32'h5, 6'd3, 32'h13, 6'd5, 32'hA, 6'd4);
        check("t5_F", out_F, 64'hA9D);
        check("t5_S", out_S, 64'h884);
        check("t5_seg", 64'(seg_pulses - s0), 64'd3);

        // T6: random legal frames split back apart by a receive-side model
        for (int f = 0; f < 200; f++) begin
            for (int i = 0; i < 3; i++) begin
                lv[i] = 6'($urandom_range(1, 21));
                wv[i] = $urandom & ((32'd1 << lv[i]) - 32'd1);
                wv[i][lv[i] - 6'd1] = 1'b1;
            end
            frame(wv[0], lv[0], wv[1], lv[1], wv[2], lv[2]);
            nseg = 0; b = 0; cur = '0;
            for (int i = 0; i < 3; i++) got_w[i] = '0;
            for (int k = 0; k < 64; k++) begin
                if (b < 32) cur[b] = out_F[k];
                b++;
                if (out_S[k]) begin
                    if (nseg < 3) got_w[nseg] = cur;
                    nseg++;
                    cur = '0;
                    b = 0;
                end
            end
            check("rt_nseg", 64'(nseg), 64'd3);
            check("rt_err", {63'd0, err}, 64'd0);
            for (int i = 0; i < 3; i++) check("rt_word", {32'd0, got_w[i]}, {32'd0, wv[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
